mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory (the memory_if memory: wr/rd strobes, 16-bit addr, 16-bit data) between two requesters.
- Round-robin arbitration with one outstanding access at a time.
- Sits between requester blocks (testers, bus masters) and the memory; owns the memory's wr, rd, addr and wr_data signals.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- RD_LAT, 1, cycles from mem_rd strobe until mem_rd_data is valid (1..4)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous active-high reset
- req  in  2  per-requester access request, bit n = requester n
- we  in  2  per-requester 1 = write, 0 = read; sampled with req
- addr0, addr1  in  ADDR_W  requester address
- wdata0, wdata1  in  DATA_W  requester write data
- gnt  out  2  one-cycle grant pulse; the request is accepted in this cycle
- rvalid  out  2  one-cycle read-data-valid pulse
- rdata  out  DATA_W  read data, shared; valid when either rvalid bit is set
- busy  out  1  high in any state other than IDLE
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data

Behaviour:
- Reset values:
  - all outputs 0; state IDLE
  - last-grant pointer = 1, so requester 0 wins the first tie
  - When rst asserts mid-access, the access is abandoned: no gnt or rvalid pulse and no strobe after reset. Requesters reissue.
- Requester rule: hold req, we, addr and wdata stable until gnt. Deassertion before gnt is legal (withdrawal).
- FSM states:
  - IDLE: if any req bit is high, pick the winner and go to ISSUE.
    - Both bits high: pick the requester other than the last-granted one.
    - One bit high: that requester wins.
    - Latch the winner's we, addr and wdata. Update the pointer.
  - ISSUE (1 cycle): gnt[winner]=1.
    - Write: mem_wr=1 with registered mem_addr/mem_wr_data, then go to IDLE.
    - Read: mem_rd=1, then go to RDWAIT.
  - RDWAIT: count RD_LAT cycles after ISSUE, capture mem_rd_data into rdata, then go to RESP.
  - RESP (1 cycle): rvalid[winner]=1 with rdata valid, then go to IDLE.
- mem_rd and mem_wr are never high together. Both are 0 outside ISSUE.
- mem_addr and mem_wr_data hold their last values between accesses.
- rdata holds its value until the next read response.
- Withdrawal: req is sampled only in IDLE. A request withdrawn before the IDLE sample is never granted.
- Latency:
  - write: req high in IDLE cycle T -> gnt and mem_wr at T+1; next arbitration at T+2
  - read: rvalid at T+2+RD_LAT
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1.
- Out-of-range RD_LAT (0 or >4): elaboration error via $error in an initial check.

Optional Feature:
- Macro: MEM_ARB_STATS_EN
- Defined:
  - adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each), counting accepted grants per requester
  - wrap at 0xFFFF -> 0x0000
  - cleared by rst
  - adds input stats_clr (1 bit): synchronous clear of both counters
    - stats_clr has priority over a simultaneous increment; the counter reads 0 next cycle
- Not defined: ports and counters are absent. Arbitration behaviour is identical.

Test Plan:
- Write then read: req0 write addr 0x0005 data 0x00A5 -> mem_wr=1 with mem_addr 0x0005 and mem_wr_data 0x00A5 one cycle after req. Then req0 read 0x0005 -> rvalid[0] and rdata 0x00A5 at T+2+RD_LAT.
- Contention: req=2'b11, both writes, held continuously for 8 grants -> gnt order 0,1,0,1,0,1,0,1; never two gnt bits in one cycle.
- Read latency sweep: RD_LAT=1 and RD_LAT=3 builds -> rvalid exactly 3 and 5 cycles after the IDLE sample; mem_rd high exactly 1 cycle.
- Withdrawal and reset:
  - req1 raised then dropped while a req0 read is in RDWAIT -> no gnt[1].
  - rst pulsed during RDWAIT -> no rvalid; all outputs 0; first post-reset tie goes to requester 0.
- Stats (MEM_ARB_STATS_EN):
  - 5 grants to requester 0 and 3 to requester 1 -> gnt_cnt0=5, gnt_cnt1=3.
  - stats_clr in the same cycle as a grant -> both counters 0.
  - Preload to 0xFFFF via 65535 grants, one more grant -> 0x0000.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port memory.
// One access is in flight at a time: IDLE picks a winner, ISSUE drives the
// memory strobe for one cycle, reads then wait RD_LAT cycles before the
// RESP cycle returns the data.
// Optional build macro MEM_ARB_STATS_EN adds per-requester grant counters
// (gnt_cnt0/gnt_cnt1) and a synchronous stats_clr input.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
`ifdef MEM_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
`endif
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  if (RD_LAT == 0 || RD_LAT > 4) begin : g_rd_lat_check
    $error("mem_port_arbiter: RD_LAT must be in 1..4");
  end

  localparam logic [2:0] LatLast = 3'(RD_LAT);

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StResp} state_t;

  state_t     state_q;
  logic       last_q;   // index of the last granted requester
  logic       win_q;    // requester owning the current access
  logic       we_q;
  logic [2:0] lat_cnt_q;
  logic       win;

  // Round-robin winner: on a tie, the requester that was not granted last.
  always_comb begin
    win = req[1];
    if (req == 2'b11) begin
      win = ~last_q;
    end
  end

  // Access FSM; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      lat_cnt_q   <= 3'd0;
      gnt         <= 2'b00;
      rvalid      <= 2'b00;
      rdata       <= '0;
      busy        <= 1'b0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      gnt    <= 2'b00;
      rvalid <= 2'b00;
      mem_wr <= 1'b0;
      mem_rd <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            win_q       <= win;
            last_q      <= win;
            we_q        <= we[win];
            gnt         <= win ? 2'b10 : 2'b01;
            mem_addr    <= win ? addr1 : addr0;
            mem_wr_data <= win ? wdata1 : wdata0;
            mem_wr      <= we[win];
            mem_rd      <= ~we[win];
            busy        <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (we_q) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            lat_cnt_q <= 3'd1;
            state_q   <= StRdWait;
          end
        end
        StRdWait: begin
          // Data is valid RD_LAT cycles after the strobe cycle.
          if (lat_cnt_q == LatLast) begin
            rdata   <= mem_rd_data;
            rvalid  <= win_q ? 2'b10 : 2'b01;
            state_q <= StResp;
          end else begin
            lat_cnt_q <= lat_cnt_q + 3'd1;
          end
        end
        StResp: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Grant counters; a clear wins over a same-cycle grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0 <= 16'd0;
      gnt_cnt1 <= 16'd0;
    end else if (stats_clr) begin
      gnt_cnt0 <= 16'd0;
      gnt_cnt1 <= 16'd0;
    end else begin
      if (gnt[0]) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (gnt[1]) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a scoreboard: pending requests are
// queued per requester, checked on grant, and read responses are queued with
// their expected data and arrival cycle.
module tb_mem_port_arbiter #(
  parameter int unsigned RD_LAT = 1
);

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic        busy, mem_wr, mem_rd;
  logic [15:0] mem_addr, mem_wr_data, mem_rd_data;
`ifdef MEM_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (16),
    .DATA_W (16),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .we          (we),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
`ifdef MEM_ARB_STATS_EN
    .stats_clr   (stats_clr),
    .gnt_cnt0    (gnt_cnt0),
    .gnt_cnt1    (gnt_cnt1),
`endif
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .busy        (busy),
    .mem_wr      (mem_wr),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  // Memory with RD_LAT cycles of read latency.
  logic [15:0] mem_arr [0:255];
  logic [15:0] lat_pipe [0:3];
  always @(posedge clk) begin
    if (mem_wr) mem_arr[mem_addr[7:0]] <= mem_wr_data;
    lat_pipe[0] <= mem_arr[mem_addr[7:0]];
    for (int i = 1; i < 4; i++) lat_pipe[i] <= lat_pipe[i-1];
  end
  assign mem_rd_data = lat_pipe[RD_LAT-1];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;
  typedef struct {
    int          port;
    logic [15:0] data;
    int          due;
  } rd_t;

  req_t        pend0[$];
  req_t        pend1[$];
  rd_t         rd_exp[$];
  int          grant_log[$];
  logic [15:0] model [0:255];
  int          cyc = 0;
  int          last_gnt_cyc = 0;
  int          last_rv_cyc = 0;
  logic [1:0]  prev_gnt = 2'b00;
  int          n_pass = 0;
  int          n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
    req_t e;
    e.we = w; e.addr = a; e.data = d;
    if (p == 0) pend0.push_back(e);
    else pend1.push_back(e);
  endtask

  // Present the head of each pending queue on an idle request line.
  task automatic drive();
    if (!req[0] && pend0.size() > 0) begin
      req[0] = 1'b1; we[0] = pend0[0].we; addr0 = pend0[0].addr; wdata0 = pend0[0].data;
    end
    if (!req[1] && pend1.size() > 0) begin
      req[1] = 1'b1; we[1] = pend1[0].we; addr1 = pend1[0].addr; wdata1 = pend1[0].data;
    end
  endtask

  task automatic observe();
    req_t e;
    rd_t  r;
    int   p;
    cyc++;
    chk("strobe_excl", {30'd0, mem_wr & mem_rd}, 32'd0);
    if (gnt != 2'b00) begin
      p = gnt[1] ? 1 : 0;
      chk("gnt_onehot", $countones(gnt), 32'd1);
      chk("gnt_pulse", {30'd0, prev_gnt}, 32'd0);
      chk("busy_in_issue", {31'd0, busy}, 32'd1);
      grant_log.push_back(p);
      last_gnt_cyc = cyc;
      if ((p == 0 && pend0.size() == 0) || (p == 1 && pend1.size() == 0)) begin
        chk("unexpected_gnt", {30'd0, gnt}, 32'd0);
      end else begin
        if (p == 0) begin e = pend0.pop_front(); req[0] = 1'b0; end
        else begin e = pend1.pop_front(); req[1] = 1'b0; end
        chk("mem_wr", {31'd0, mem_wr}, {31'd0, e.we});
        chk("mem_rd", {31'd0, mem_rd}, {31'd0, ~e.we});
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, e.addr});
        if (e.we) begin
          chk("mem_wr_data", {16'd0, mem_wr_data}, {16'd0, e.data});
          model[e.addr[7:0]] = e.data;
        end else begin
          r.port = p; r.data = model[e.addr[7:0]]; r.due = cyc + 1 + int'(RD_LAT);
          rd_exp.push_back(r);
        end
      end
    end else begin
      chk("strobe_idle", {30'd0, mem_wr, mem_rd}, 32'd0);
    end
    if (rvalid != 2'b00) begin
      last_rv_cyc = cyc;
      if (rd_exp.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, rvalid}, 32'd0);
      end else begin
        r = rd_exp.pop_front();
        chk("rvalid_port", {30'd0, rvalid}, (r.port == 1) ? 32'd2 : 32'd1);
        chk("rdata", {16'd0, rdata}, {16'd0, r.data});
        chk("rd_due", cyc, r.due);
      end
    end
    prev_gnt = gnt;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    drive();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (k < budget && (pend0.size() > 0 || pend1.size() > 0 || rd_exp.size() > 0 ||
                          busy || req != 2'b00)) begin
      tick();
      k++;
    end
    chk("drain_timeout", pend0.size() + pend1.size() + rd_exp.size(), 32'd0);
  endtask

  task automatic wait_gnt(input int n_before, input int budget);
    int k = 0;
    while (k < budget && grant_log.size() <= n_before) begin
      tick();
      k++;
    end
    chk("gnt_timeout", {31'd0, grant_log.size() > n_before}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, rvalid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_strobes"}, {30'd0, mem_wr, mem_rd}, 32'd0);
    chk({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wr_data"}, {16'd0, mem_wr_data}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, rdata}, 32'd0);
  endtask

  initial begin
    int n;
    int t0;
    rst = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // Write then read back through requester 0.
    push(0, 1'b1, 16'h0005, 16'h00A5);
    t0 = cyc;
    drive();
    drain(20);
    chk("wr_latency", last_gnt_cyc, t0 + 1);
    push(0, 1'b0, 16'h0005, 16'h0000);
    t0 = cyc;
    drive();
    drain(20);
    chk("rd_latency", last_rv_cyc, t0 + 2 + int'(RD_LAT));
    chk("rdata_hold", {16'd0, rdata}, 32'h00A5);
    chk("mem_addr_hold", {16'd0, mem_addr}, 32'h0005);

    // Reset during RDWAIT abandons the read; pointer returns to requester 0.
    n = grant_log.size();
    push(0, 1'b0, 16'h0005, 16'h0000);
    drive();
    wait_gnt(n, 10);
    tick();
    rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    rd_exp.delete(); pend0.delete(); pend1.delete();
    req = 2'b00; prev_gnt = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) tick();
    chk("no_rvalid_after_reset", {31'd0, last_rv_cyc > cyc - 8}, 32'd0);
    n = grant_log.size();
    push(0, 1'b1, 16'h0010, 16'h1111);
    push(1, 1'b1, 16'h0011, 16'h2222);
    drive();
    drain(20);
    chk("tie_after_reset", grant_log[n], 32'd0);

    // Continuous contention: grants strictly alternate.
    n = grant_log.size();
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b1, 16'h0020 + 16'(i), 16'h3000 + 16'(i));
      push(1, 1'b1, 16'h0040 + 16'(i), 16'h4000 + 16'(i));
    end
    drive();
    drain(60);
    chk("rr_count", grant_log.size() - n, 32'd8);
    for (int i = 0; i < 8; i++) chk("rr_order", grant_log[n+i], i % 2);
    push(1, 1'b0, 16'h0041, 16'h0000);
    drive();
    drain(20);
    chk("rdata_port1", {16'd0, rdata}, 32'h4001);

    // Requester 1 raised and withdrawn while a read sits in RDWAIT.
    n = grant_log.size();
    push(0, 1'b0, 16'h0020, 16'h0000);
    drive();
    wait_gnt(n, 10);
    tick();
    req[1] = 1'b1; we[1] = 1'b1; addr1 = 16'h0077; wdata1 = 16'hBEEF;
    tick();
    req[1] = 1'b0;
    drain(20);
    chk("withdraw_grants", grant_log.size() - n, 32'd1);
    chk("withdraw_rdata", {16'd0, rdata}, 32'h3000);

`ifdef MEM_ARB_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    tick();
    chk("cnt0_cleared", {16'd0, gnt_cnt0}, 32'd0);
    for (int i = 0; i < 5; i++) push(0, 1'b1, 16'h0080 + 16'(i), 16'h5000 + 16'(i));
    for (int i = 0; i < 3; i++) push(1, 1'b1, 16'h0090 + 16'(i), 16'h6000 + 16'(i));
    drive();
    drain(60);
    tick();
    chk("gnt_cnt0", {16'd0, gnt_cnt0}, 32'd5);
    chk("gnt_cnt1", {16'd0, gnt_cnt1}, 32'd3);
    n = grant_log.size();
    push(0, 1'b1, 16'h00A0, 16'h7000);
    drive();
    tick();
    chk("clr_with_gnt_seen", grant_log.size() - n, 32'd1);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("clr_cnt0", {16'd0, gnt_cnt0}, 32'd0);
    chk("clr_cnt1", {16'd0, gnt_cnt1}, 32'd0);
    drain(20);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
